// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Single-port word memory answering CPU read/write strobes after a
//            fixed wait, with one-cycle completion pulses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 12,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic              o_ready,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_wack,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_latency = 4'(LATENCY);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_is_write;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_rdata;
    logic              r_err;
    logic [DWIDTH-1:0] r_mem [0:(2**AWIDTH)-1];

    logic w_idle;
    logic w_accept;
    logic w_conflict;
    logic w_access;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle && (i_read ^ i_write);
    assign w_conflict = w_idle && i_read && i_write;
    // The array is touched on the last WAIT cycle so data is ready in RESP.
    assign w_access   = (r_state == ST_WAIT) && (r_cnt == 4'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_access) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_conflict;
            if (w_accept) begin
                r_cnt      <= c_latency;
                r_is_write <= i_write;
                r_addr     <= i_addr;
                r_wdata    <= i_wdata;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !r_is_write) begin
                r_rdata <= r_mem[r_addr];
            end
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_access && r_is_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign o_ready  = w_idle;
    assign o_rdata  = r_rdata;
    assign o_rvalid = (r_state == ST_RESP) && !r_is_write;
    assign o_wack   = (r_state == ST_RESP) && r_is_write;
    assign o_done   = o_rvalid | o_wack;
    assign o_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Scoreboard bench for mem_responder with LATENCY=2 and LATENCY=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    typedef struct {
        int          kind;   // 0 read, 1 write ack, 2 conflict error
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic        a_rst_n, a_read, a_write, a_ready, a_rvalid, a_wack, a_done, a_err;
    logic [11:0] a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_rst_n, b_read, b_write, b_ready, b_rvalid, b_wack, b_done, b_err;
    logic [11:0] b_addr;
    logic [15:0] b_wdata, b_rdata;

    mem_responder #(.DWIDTH(16), .AWIDTH(12), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset_n(a_rst_n), .i_read(a_read), .i_write(a_write),
        .i_addr(a_addr), .i_wdata(a_wdata), .o_ready(a_ready), .o_rdata(a_rdata),
        .o_rvalid(a_rvalid), .o_wack(a_wack), .o_done(a_done), .o_err(a_err)
    );

    mem_responder #(.DWIDTH(16), .AWIDTH(12), .LATENCY(1)) u_dut_b (
        .clk(clk), .reset_n(b_rst_n), .i_read(b_read), .i_write(b_write),
        .i_addr(b_addr), .i_wdata(b_wdata), .o_ready(b_ready), .o_rdata(b_rdata),
        .o_rvalid(b_rvalid), .o_wack(b_wack), .o_done(b_done), .o_err(b_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic check_resp(input string nm, input bit have, input exp_t e,
                              input logic rv, input logic wk, input logic er,
                              input logic [15:0] rd, input logic dn, input logic rdy,
                              input int now);
        int kind;
        bit ok;
        kind = er ? 2 : (wk ? 1 : 0);
        ok = have && (kind == e.kind) && (now == e.cyc) && !(rv && wk)
             && !(er && (rv || wk)) && (dn === (rv | wk))
             && (kind != 0 || rd === e.data) && (kind != 2 || rdy === 1'b1);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got kind=%0d cyc=%0d rdata=%h done=%b ready=%b, required queued=%0b kind=%0d cyc=%0d rdata=%h",
                     nm, kind, now, rd, dn, rdy, have, e.kind, e.cyc, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (a_rvalid || a_wack || a_err) begin : mon_a
            exp_t e;
            bit   h;
            h = (qa.size() > 0);
            if (h) e = qa.pop_front();
            else   e = '{kind: -1, data: 16'h0, cyc: -1};
            check_resp("resp_lat2", h, e, a_rvalid, a_wack, a_err, a_rdata, a_done, a_ready, cyc);
        end
    end

    always @(negedge clk) begin
        if (b_rvalid || b_wack || b_err) begin : mon_b
            exp_t e;
            bit   h;
            h = (qb.size() > 0);
            if (h) e = qb.pop_front();
            else   e = '{kind: -1, data: 16'h0, cyc: -1};
            check_resp("resp_lat1", h, e, b_rvalid, b_wack, b_err, b_rdata, b_done, b_ready, cyc);
        end
    end

    task automatic wait_idle(input bit inst);
        int g;
        g = 0;
        while (!(inst ? b_ready : a_ready) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got o_ready=0 for %0d cycles, required 1", g);
        end
    endtask

    // Drives one request for a single cycle; returns #1 into the following cycle.
    task automatic issue(input bit inst, input bit rd, input bit wr,
                         input logic [11:0] addr, input logic [15:0] wd,
                         input bit push, input int kind, input logic [15:0] ed);
        exp_t e;
        wait_idle(inst);
        if (inst) begin
            b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
        end else begin
            a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
        end
        e.kind = kind;
        e.data = ed;
        e.cyc  = cyc + ((kind == 2) ? 1 : (inst ? 2 : 3));
        if (push) begin
            if (inst) qb.push_back(e);
            else      qa.push_back(e);
        end
        @(posedge clk); #1;
        if (inst) begin
            b_read = 1'b0; b_write = 1'b0;
        end else begin
            a_read = 1'b0; a_write = 1'b0;
        end
    endtask

    initial begin
        a_rst_n = 1'b0; a_read = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
        b_rst_n = 1'b0; b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready",  16'(a_ready), 16'h1);
        check_val("rst_rdata",  a_rdata, 16'h0000);
        check_val("rst_pulses", {12'h0, a_rvalid, a_wack, a_done, a_err}, 16'h0);
        check_val("rst_b_rdata", b_rdata, 16'h0000);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read back, LATENCY=2
        issue(0, 0, 1, 12'h123, 16'hBEEF, 1, 1, 16'h0);
        issue(0, 1, 0, 12'h123, 16'h0,    1, 0, 16'hBEEF);

        // Reads pulsed while busy must be dropped
        issue(0, 0, 1, 12'h010, 16'h1111, 1, 1, 16'h0);
        a_read = 1'b1; a_addr = 12'h010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_read = 1'b0;
        wait_idle(0);
        check_val("rdata_hold", a_rdata, 16'hBEEF);
        issue(0, 1, 0, 12'h010, 16'h0, 1, 0, 16'h1111);

        // Conflicting strobes: error pulse, earlier write intact
        issue(0, 0, 1, 12'h055, 16'hAAAA, 1, 1, 16'h0);
        issue(0, 1, 1, 12'h055, 16'h0000, 1, 2, 16'h0);
        issue(0, 1, 0, 12'h055, 16'h0,    1, 0, 16'hAAAA);

        // Reset during WAIT loses the pending write at the top address
        issue(0, 0, 1, 12'hFFF, 16'h0000, 1, 1, 16'h0);
        issue(0, 0, 1, 12'hFFF, 16'h5A5A, 0, 1, 16'h0);
        a_rst_n = 1'b0;
        #1;
        check_val("abort_ready", 16'(a_ready), 16'h1);
        repeat (2) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        check_val("abort_rdata", a_rdata, 16'h0000);
        issue(0, 1, 0, 12'hFFF, 16'h0, 1, 0, 16'h0000);

        // LATENCY=1 instance at the top address
        issue(1, 0, 1, 12'hFFF, 16'h7E7E, 1, 1, 16'h0);
        issue(1, 1, 0, 12'hFFF, 16'h0,    1, 0, 16'h7E7E);
        wait_idle(1);
        check_val("lat1_rdata", b_rdata, 16'h7E7E);

        repeat (10) @(posedge clk);
        #1;
        check_val("lat2_pending", 16'(qa.size()), 16'h0);
        check_val("lat1_pending", 16'(qb.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
